// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Main control unit for a classic multi-cycle MIPS-style datapath. A 4-bit
// state register sequences each instruction through fetch, decode and the
// opcode-specific execute / memory / write-back steps. Every datapath
// control is a Moore decode of the registered state. The only exceptions are
// a few strobes that are additionally qualified by mem_ready (memory
// handshake) or by zero (branch resolution).
//
// Two sticky diagnostics are kept alongside the sequencer:
//   illegal_op  - an opcode outside the supported set reached DECODE
//   err_timeout - a memory access waited TIMEOUT cycles without mem_ready
// Both clear only on reset.
//
// Parameters
//   TIMEOUT     memory wait cycles after which err_timeout sets (default 255)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, active-low
//   op[5:0]      in   opcode from the instruction register
//   zero         in   ALU zero flag
//   mem_ready    in   memory access completes this cycle
//   mem_req      out  memory access requested
//   iord         out  memory address select: 0 = PC, 1 = ALUOut
//   mem_write    out  store strobe
//   ir_write     out  instruction register load enable
//   reg_dst      out  register write select: 1 = rd, 0 = rt
//   mem_to_reg   out  write-back select: 1 = memory data, 0 = ALUOut
//   reg_write    out  register file write enable
//   alu_src_a    out  ALU A select: 0 = PC, 1 = register A
//   alu_src_b    out  ALU B select: 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op[1:0]  out  ALU class: 00 add, 01 subtract, 10 funct decode
//   pc_src[1:0]  out  next PC: 00 ALU result, 01 ALUOut, 10 jump target
//   pc_en        out  PC load enable
//   retire       out  one-cycle pulse when an instruction completes
//   illegal_op   out  sticky: unsupported opcode seen
//   err_timeout  out  sticky: memory wait reached TIMEOUT
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       retire,
    output logic       illegal_op,
    output logic       err_timeout
);

    // Supported opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // The wait counter is at least 8 bits and grows if TIMEOUT needs more.
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t        state_r;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_next_s;
    logic          waiting_s;
    logic          illegal_r;
    logic          timeout_r;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic op_is_legal(input logic [5:0] o);
        logic legal;
        case (o)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:               legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Branch resolution: beq takes the branch on zero, bne on not-zero.
    function automatic logic branch_taken(input logic [5:0] o, input logic z);
        logic taken;
        case (o)
            OP_BEQ:  taken = z;
            OP_BNE:  taken = ~z;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // State sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    if (mem_ready) state_r <= DECODE;
                    else           state_r <= FETCH;
                end
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:   state_r <= MEMADR;
                        OP_RTYPE:       state_r <= EXECUTE;
                        OP_BEQ, OP_BNE: state_r <= BRANCH;
                        OP_ADDI:        state_r <= ADDIEXEC;
                        OP_J:           state_r <= JUMP;
                        default:        state_r <= FETCH;
                    endcase
                end
                MEMADR: begin
                    if (op == OP_LW) state_r <= MEMRD;
                    else             state_r <= MEMWR;
                end
                MEMRD: begin
                    if (mem_ready) state_r <= MEMWB;
                    else           state_r <= MEMRD;
                end
                MEMWB:    state_r <= FETCH;
                MEMWR: begin
                    if (mem_ready) state_r <= FETCH;
                    else           state_r <= MEMWR;
                end
                EXECUTE:  state_r <= ALUWB;
                ALUWB:    state_r <= FETCH;
                BRANCH:   state_r <= FETCH;
                ADDIEXEC: state_r <= ADDIWB;
                ADDIWB:   state_r <= FETCH;
                JUMP:     state_r <= FETCH;
                // Codes 12-15 are unreachable; recover to FETCH.
                default:  state_r <= FETCH;
            endcase
        end
    end

    // Moore output decode, qualified by mem_ready / zero where the handshake needs it.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        retire     = 1'b0;
        case (state_r)
            FETCH: begin
                // PC + 4 is computed every cycle but only loaded with the instruction.
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = 2'b11;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = branch_taken(op, zero);
                retire    = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Next wait count: counts stalled memory cycles, saturates at TIMEOUT.
    always_comb begin
        waiting_s = mem_req & ~mem_ready;
        if (!waiting_s) begin
            wait_next_s = {CW{1'b0}};
        end else if (wait_cnt_r == TIMEOUT_C) begin
            wait_next_s = wait_cnt_r;
        end else begin
            wait_next_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Wait counter and sticky diagnostic flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= {CW{1'b0}};
            illegal_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            wait_cnt_r <= wait_next_s;
            // Flag on the same edge the count reaches TIMEOUT.
            if (waiting_s && (wait_next_s == TIMEOUT_C)) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
            if ((state_r == DECODE) && !op_is_legal(op)) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    assign illegal_op  = illegal_r;
    assign err_timeout = timeout_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for multi_cycle_ctrl. The main instance uses
// the default TIMEOUT. A second instance with TIMEOUT=4 exercises the
// memory-wait watchdog.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals.
    logic       rst_n, zero, mem_ready;
    logic [5:0] op;
    logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, pc_en, retire, illegal_op, err_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] st;

    // TIMEOUT=4 instance signals.
    logic       rst_n_t, zero_t, mem_ready_t;
    logic [5:0] op_t;
    logic       mem_req_t, iord_t, mem_write_t, ir_write_t, reg_dst_t, mem_to_reg_t;
    logic       reg_write_t, alu_src_a_t, pc_en_t, retire_t, illegal_op_t, err_timeout_t;
    logic [1:0] alu_src_b_t, alu_op_t, pc_src_t;
    logic [3:0] st_t;

    int total = 0;
    int bad   = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_en(pc_en), .retire(retire),
        .illegal_op(illegal_op), .err_timeout(err_timeout)
    );

    multi_cycle_ctrl #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n_t), .op(op_t), .zero(zero_t), .mem_ready(mem_ready_t),
        .mem_req(mem_req_t), .iord(iord_t), .mem_write(mem_write_t), .ir_write(ir_write_t),
        .reg_dst(reg_dst_t), .mem_to_reg(mem_to_reg_t), .reg_write(reg_write_t),
        .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t), .alu_op(alu_op_t),
        .pc_src(pc_src_t), .pc_en(pc_en_t), .retire(retire_t),
        .illegal_op(illegal_op_t), .err_timeout(err_timeout_t)
    );

    assign st   = dut.state_r;
    assign st_t = dut_t.state_r;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op = OP_RTYPE; zero = 1'b0; mem_ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        #1;
        total++; if (st !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_mem_req got=%b want=1", mem_req); end
        total++; if (alu_src_b !== 2'b01) begin bad++; $display("FAIL reset_alu_src_b got=%b want=01", alu_src_b); end
        total++; if (ir_write !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("FAIL reset_ir_pc got=%b%b want=00", ir_write, pc_en); end
        total++; if (illegal_op !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", illegal_op, err_timeout); end
    endtask

    task automatic test_lw;
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (st !== exp_st[i]) begin bad++; $display("FAIL lw_state c%0d got=%0d want=%0d", i, st, exp_st[i]); end
            total++; if (reg_write !== (i == 4)) begin bad++; $display("FAIL lw_reg_write c%0d got=%b", i, reg_write); end
            total++; if (retire !== (i == 4)) begin bad++; $display("FAIL lw_retire c%0d got=%b", i, retire); end
            if (i == 0) begin
                total++; if (ir_write !== 1'b1 || pc_en !== 1'b1) begin bad++; $display("FAIL lw_fetch_load got=%b%b want=11", ir_write, pc_en); end
            end
            if (i == 3) begin
                total++; if (mem_req !== 1'b1 || iord !== 1'b1) begin bad++; $display("FAIL lw_memrd got=%b%b want=11", mem_req, iord); end
            end
            tick;
        end
        total++; if (st !== 4'd0) begin bad++; $display("FAIL lw_back_fetch got=%0d want=0", st); end
    endtask

    task automatic test_sw;
        logic       rdy    [7];
        logic [3:0] exp_st [7];
        int nwr, nret, nreg, ret_at;
        rdy    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        nwr = 0; nret = 0; nreg = 0; ret_at = -1;
        op = OP_SW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            total++; if (st !== exp_st[i]) begin bad++; $display("FAIL sw_state c%0d got=%0d want=%0d", i, st, exp_st[i]); end
            if (mem_write === 1'b1) nwr++;
            if (retire === 1'b1) begin nret++; ret_at = i; end
            if (reg_write === 1'b1) nreg++;
            tick;
        end
        total++; if (nwr != 4) begin bad++; $display("FAIL sw_mem_write_cycles got=%0d want=4", nwr); end
        total++; if (nret != 1 || ret_at != 6) begin bad++; $display("FAIL sw_retire got=%0d@%0d want=1@6", nret, ret_at); end
        total++; if (nreg != 0) begin bad++; $display("FAIL sw_reg_write got=%0d want=0", nreg); end
        total++; if (st !== 4'd0) begin bad++; $display("FAIL sw_back_fetch got=%0d want=0", st); end
    endtask

    task automatic test_branch;
        logic [5:0] ops [4];
        logic       zs  [4];
        logic       ens [4];
        ops = '{OP_BEQ, OP_BNE, OP_BEQ, OP_BNE};
        zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
        ens = '{1'b1, 1'b0, 1'b0, 1'b1};
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = ops[k]; zero = zs[k];
            tick; tick;
            total++; if (st !== 4'd8) begin bad++; $display("FAIL br_state k%0d got=%0d want=8", k, st); end
            total++; if (pc_en !== ens[k]) begin bad++; $display("FAIL br_pc_en k%0d got=%b want=%b", k, pc_en, ens[k]); end
            total++; if (pc_src !== 2'b01 || alu_op !== 2'b01 || retire !== 1'b1) begin
                bad++; $display("FAIL br_ctrl k%0d got=%b/%b/%b want=01/01/1", k, pc_src, alu_op, retire); end
            tick;
            total++; if (st !== 4'd0) begin bad++; $display("FAIL br_back_fetch k%0d got=%0d want=0", k, st); end
        end
        zero = 1'b0;
    endtask

    task automatic test_alu_ops;
        logic [5:0] ops [3];
        logic [3:0] seq [3][4];
        int         len [3];
        ops = '{OP_RTYPE, OP_ADDI, OP_J};
        seq = '{'{4'd0, 4'd1, 4'd6, 4'd7}, '{4'd0, 4'd1, 4'd9, 4'd10}, '{4'd0, 4'd1, 4'd11, 4'd0}};
        len = '{4, 4, 3};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            for (int c = 0; c < len[k]; c++) begin
                #1;
                total++; if (st !== seq[k][c]) begin bad++; $display("FAIL alu_state k%0d c%0d got=%0d want=%0d", k, c, st, seq[k][c]); end
                total++; if (retire !== (c == len[k] - 1)) begin bad++; $display("FAIL alu_retire k%0d c%0d got=%b", k, c, retire); end
                case (seq[k][c])
                    4'd1: begin total++; if (alu_src_b !== 2'b11) begin bad++; $display("FAIL decode_alu_src_b got=%b want=11", alu_src_b); end end
                    4'd6: begin total++; if (alu_op !== 2'b10 || alu_src_b !== 2'b00 || alu_src_a !== 1'b1) begin bad++; $display("FAIL execute_ctrl got=%b/%b/%b", alu_op, alu_src_b, alu_src_a); end end
                    4'd7: begin total++; if (reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin bad++; $display("FAIL aluwb_ctrl got=%b%b%b want=110", reg_dst, reg_write, mem_to_reg); end end
                    4'd9: begin total++; if (alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin bad++; $display("FAIL addiexec_ctrl got=%b/%b", alu_src_b, alu_src_a); end end
                    4'd10: begin total++; if (reg_dst !== 1'b0 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin bad++; $display("FAIL addiwb_ctrl got=%b%b%b want=010", reg_dst, reg_write, mem_to_reg); end end
                    4'd11: begin total++; if (pc_src !== 2'b10 || pc_en !== 1'b1) begin bad++; $display("FAIL jump_ctrl got=%b/%b want=10/1", pc_src, pc_en); end end
                    default: begin end
                endcase
                tick;
            end
            total++; if (st !== 4'd0) begin bad++; $display("FAIL alu_back_fetch k%0d got=%0d want=0", k, st); end
        end
    endtask

    task automatic test_illegal;
        int nret;
        nret = 0;
        mem_ready = 1'b1; op = OP_BAD;
        #1;
        if (retire === 1'b1) nret++;
        tick;
        total++; if (st !== 4'd1 || illegal_op !== 1'b0) begin bad++; $display("FAIL ill_decode got=%0d/%b want=1/0", st, illegal_op); end
        if (retire === 1'b1) nret++;
        tick;
        total++; if (st !== 4'd0) begin bad++; $display("FAIL ill_next_state got=%0d want=0", st); end
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b want=1", illegal_op); end
        total++; if (nret != 0) begin bad++; $display("FAIL ill_no_retire got=%0d want=0", nret); end
        op = OP_J;
        for (int n = 0; n < 30; n++) begin
            if (retire === 1'b1) nret++;
            tick;
        end
        total++; if (nret != 10) begin bad++; $display("FAIL ill_ten_jumps got=%0d want=10", nret); end
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b want=1", illegal_op); end
    endtask

    task automatic test_reset_midwait;
        logic saw_wr;
        saw_wr = 1'b0;
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL midwait_pre_flag got=%b want=1", illegal_op); end
        op = OP_LW; mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (mem_write === 1'b1) saw_wr = 1'b1;
            tick;
        end
        total++; if (st !== 4'd3) begin bad++; $display("FAIL midwait_in_memrd got=%0d want=3", st); end
        total++; if (dut.wait_cnt_r !== 8'd2) begin bad++; $display("FAIL midwait_count got=%0d want=2", dut.wait_cnt_r); end
        rst_n = 1'b0;
        if (mem_write === 1'b1) saw_wr = 1'b1;
        tick;
        total++; if (st !== 4'd0) begin bad++; $display("FAIL midwait_reset_state got=%0d want=0", st); end
        total++; if (illegal_op !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL midwait_reset_flags got=%b%b want=00", illegal_op, err_timeout); end
        total++; if (dut.wait_cnt_r !== 8'd0) begin bad++; $display("FAIL midwait_reset_count got=%0d want=0", dut.wait_cnt_r); end
        rst_n = 1'b1;
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midwait_release_mem_req got=%b want=1", mem_req); end
        total++; if (saw_wr !== 1'b0) begin bad++; $display("FAIL midwait_mem_write got=%b want=0", saw_wr); end
    endtask

    task automatic test_timeout;
        // Default instance: ten stalled fetch cycles stay far below 255.
        mem_ready = 1'b0;
        for (int c = 0; c < 10; c++) tick;
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_default_early got=%b want=0", err_timeout); end
        // TIMEOUT=4 instance.
        mem_ready_t = 1'b0; op_t = OP_LW; zero_t = 1'b0;
        tick;
        rst_n_t = 1'b1;
        #1;
        total++; if (st_t !== 4'd0 || err_timeout_t !== 1'b0) begin bad++; $display("FAIL to_start got=%0d/%b want=0/0", st_t, err_timeout_t); end
        for (int k = 1; k <= 6; k++) begin
            tick;
            total++; if (err_timeout_t !== (k >= 4)) begin bad++; $display("FAIL to_flag w%0d got=%b want=%b", k, err_timeout_t, (k >= 4)); end
            total++; if (st_t !== 4'd0 || ir_write_t !== 1'b0) begin bad++; $display("FAIL to_wait w%0d got=%0d/%b want=0/0", k, st_t, ir_write_t); end
        end
        mem_ready_t = 1'b1;
        #1;
        total++; if (ir_write_t !== 1'b1 || pc_en_t !== 1'b1) begin bad++; $display("FAIL to_ready_load got=%b%b want=11", ir_write_t, pc_en_t); end
        tick;
        total++; if (st_t !== 4'd1 || err_timeout_t !== 1'b1) begin bad++; $display("FAIL to_after_ready got=%0d/%b want=1/1", st_t, err_timeout_t); end
    endtask

    initial begin
        rst_n_t = 1'b0; op_t = OP_RTYPE; zero_t = 1'b0; mem_ready_t = 1'b0;
        test_reset;
        test_lw;
        test_sw;
        test_branch;
        test_alu_ops;
        test_illegal;
        test_reset_midwait;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
